// File: rtl/adc733_pkg.sv
// rtl/adc733_pkg.sv - shared widths, defaults and FSM states for the AD733 frame buffer
package adc733_pkg;

    localparam int ADC_NCH = 6;
    localparam int ADC_DW  = 16;
    localparam int CH_W    = 3;
    localparam int FCNT_W  = 16;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        DROP
    } fb_state_t;

endpackage

// File: rtl/adc733_commit_fifo.sv
// rtl/adc733_commit_fifo.sv - {ch, data} FIFO whose read side only sees committed entries
module adc733_commit_fifo #(
    parameter int DW    = 16,
    parameter int CHW   = 3,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [DW-1:0]  wr_data,
    input  logic           commit,
    input  logic           rollback,
    input  logic           pop,
    output logic           rd_valid,
    output logic [CHW-1:0] rd_ch,
    output logic [DW-1:0]  rd_data,
    output logic [PW-1:0]  occupancy
);

    logic [CHW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     cwptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     wbase;
    logic [PW-1:0]     wnext;

    // A rollback and a write in the same cycle restart the frame at the committed pointer.
    assign wbase = rollback ? cwptr : wptr;
    assign wnext = wbase + PW'(wr_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            cwptr <= '0;
            rptr  <= '0;
        end else begin
            wptr <= wnext;
            if (commit) begin
                cwptr <= wnext;
            end
            if (pop && rd_valid) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wbase[AW-1:0]] <= {wr_ch, wr_data};
        end
    end

    assign rd_valid         = (rptr != cwptr);
    assign {rd_ch, rd_data} = mem[rptr[AW-1:0]];
    assign occupancy        = cwptr - rptr;

endmodule

// File: rtl/adc733_frame_buf.sv
// rtl/adc733_frame_buf.sv - frame-aligning buffer committing only complete channel frames
module adc733_frame_buf
    import adc733_pkg::*;
#(
    parameter int NCH   = ADC_NCH,
    parameter int DW    = ADC_DW,
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              s_valid,
    input  logic [CH_W-1:0]   s_ch,
    input  logic [DW-1:0]     s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [CH_W-1:0]   m_ch,
    output logic              m_sof,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              overflow,
    output logic              seq_err,
    input  logic              clr_err
);

    localparam int              PW        = $clog2(DEPTH) + 1;
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NCH - 1);
    localparam logic [PW-1:0]   SPACE_MAX = PW'(DEPTH - NCH);

    fb_state_t       state;
    fb_state_t       state_nxt;
    logic [CH_W-1:0] exp_ch;
    logic [CH_W-1:0] exp_ch_nxt;
    logic            wr_en;
    logic            commit;
    logic            rollback;
    logic            restart;
    logic            frame_done;
    logic            set_ovf;
    logic            set_seq;
    logic            has_space;
    logic [PW-1:0]   occupancy;

    // Occupancy counts committed entries only, so an in-flight pop never frees space early.
    assign has_space = (occupancy <= SPACE_MAX);

    always_comb begin
        state_nxt  = state;
        exp_ch_nxt = exp_ch;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        restart    = 1'b0;
        frame_done = 1'b0;
        set_ovf    = 1'b0;
        set_seq    = 1'b0;
        if (sync) begin
            rollback  = 1'b1;
            state_nxt = HUNT;
        end else if (s_valid) begin
            if (state == COLLECT) begin
                if (s_ch == exp_ch) begin
                    wr_en = 1'b1;
                    if (exp_ch == LAST_CH) begin
                        commit     = 1'b1;
                        frame_done = 1'b1;
                        state_nxt  = HUNT;
                    end else begin
                        exp_ch_nxt = exp_ch + 1'b1;
                    end
                end else begin
                    set_seq   = 1'b1;
                    rollback  = 1'b1;
                    state_nxt = HUNT;
                    restart   = (s_ch == '0);
                end
            end else begin
                restart = (s_ch == '0);
            end
            if (restart) begin
                if (has_space) begin
                    wr_en = 1'b1;
                    if (NCH == 1) begin
                        commit     = 1'b1;
                        frame_done = 1'b1;
                        state_nxt  = HUNT;
                    end else begin
                        state_nxt  = COLLECT;
                        exp_ch_nxt = CH_W'(1);
                    end
                end else begin
                    set_ovf   = 1'b1;
                    state_nxt = DROP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            exp_ch    <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state  <= state_nxt;
            exp_ch <= exp_ch_nxt;
            if (sync) begin
                frame_cnt <= '0;
            end else if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (set_seq) begin
                seq_err <= 1'b1;
            end else if (clr_err) begin
                seq_err <= 1'b0;
            end
        end
    end

    adc733_commit_fifo #(
        .DW    (DW),
        .CHW   (CH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_ch     (s_ch),
        .wr_data   (s_data),
        .commit    (commit),
        .rollback  (rollback),
        .pop       (m_ready),
        .rd_valid  (m_valid),
        .rd_ch     (m_ch),
        .rd_data   (m_data),
        .occupancy (occupancy)
    );

    assign m_sof = m_valid && (m_ch == '0);

endmodule

// File: tb/tb_adc733_frame_buf.sv
// tb/tb_adc733_frame_buf.sv - directed self-checking bench for adc733_frame_buf
module tb_adc733_frame_buf;

    localparam int NCH   = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync = 1'b0;
    logic          s_valid = 1'b0;
    logic [2:0]    s_ch = '0;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic [2:0]    m_ch;
    logic          m_sof;
    logic [15:0]   frame_cnt;
    logic          overflow;
    logic          seq_err;
    logic          clr_err = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [18:0] prev_word = '0;

    always #5 clk = ~clk;

    adc733_frame_buf #(
        .NCH   (NCH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .s_valid   (s_valid),
        .s_ch      (s_ch),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .m_sof     (m_sof),
        .frame_cnt (frame_cnt),
        .overflow  (overflow),
        .seq_err   (seq_err),
        .clr_err   (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Pops are observed on the falling edge, away from the edge that performs them.
    always @(negedge clk) begin
        logic [31:0] want;
        if (!rst && m_valid && prev_stall) begin
            chk("stable", 32'({m_ch, m_data}), 32'(prev_word));
        end
        if (!rst && m_valid && m_ready) begin
            want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_0000;
            chk("pop", 32'({m_ch, m_data}), want);
            chk("sof", 32'(m_sof), 32'(want[18:16] == 3'd0));
        end
        prev_stall = !rst && m_valid && !m_ready;
        prev_word  = {m_ch, m_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_ch    = 3'(ch);
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] sample(input int k, input int ch);
        return 16'(32'h0100 + ch + 32'h1000 * k);
    endfunction

    task automatic frame(input int k, input bit keep);
        for (int ch = 0; ch < NCH; ch++) begin
            if (keep) exp_q.push_back({3'(ch), sample(k, ch)});
            send(ch, sample(k, ch));
        end
    endtask

    task automatic do_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || m_valid); i++) tick();
        chk({tag, "_q"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_v"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_seq", 32'(seq_err), 32'd0);

        // Clean frames with commit-latency checks on the first one.
        do_sync();
        for (int ch = 0; ch < NCH - 1; ch++) begin
            exp_q.push_back({3'(ch), sample(0, ch)});
            send(ch, sample(0, ch));
        end
        chk("precommit_v", 32'(m_valid), 32'd0);
        exp_q.push_back({3'd5, sample(0, 5)});
        send(5, sample(0, 5));
        chk("commit_v", 32'(m_valid), 32'd1);
        chk("commit_cnt", 32'(frame_cnt), 32'd1);
        frame(1, 1'b1);
        frame(2, 1'b1);
        wait_drain("clean");
        chk("clean_cnt", 32'(frame_cnt), 32'd3);
        chk("clean_seq", 32'(seq_err), 32'd0);
        chk("clean_ovf", 32'(overflow), 32'd0);

        // Order error, then an intact frame.
        do_sync();
        chk("sync_cnt", 32'(frame_cnt), 32'd0);
        send(0, sample(3, 0));
        send(1, sample(3, 1));
        send(2, sample(3, 2));
        send(4, sample(3, 4));
        chk("order_seq", 32'(seq_err), 32'd1);
        chk("order_v", 32'(m_valid), 32'd0);
        frame(3, 1'b1);
        wait_drain("order");
        chk("order_cnt", 32'(frame_cnt), 32'd1);
        clear_err();
        chk("order_clr", 32'(seq_err), 32'd0);

        // A ch0 inside a frame aborts it and starts a new one.
        send(0, 16'hDEAD);
        send(1, 16'hBEEF);
        frame(4, 1'b1);
        wait_drain("restart");
        chk("restart_seq", 32'(seq_err), 32'd1);
        chk("restart_cnt", 32'(frame_cnt), 32'd2);
        clear_err();

        // Overflow: 5 frames fit (occupancy 24 <= 26), the 6th does not (30 > 26).
        m_ready = 1'b0;
        do_sync();
        for (int k = 0; k < 5; k++) frame(10 + k, 1'b1);
        chk("ovf_pre", 32'(overflow), 32'd0);
        frame(15, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(frame_cnt), 32'd5);
        chk("ovf_v", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        wait_drain("ovf_drain");
        frame(6, 1'b1);
        wait_drain("ovf_after");
        chk("ovf_after_cnt", 32'(frame_cnt), 32'd6);
        clear_err();
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Sync mid-frame, and a sync coinciding with a ch3 strobe.
        send(0, sample(7, 0));
        send(1, sample(7, 1));
        send(2, sample(7, 2));
        do_sync();
        chk("msync_v", 32'(m_valid), 32'd0);
        chk("msync_cnt", 32'(frame_cnt), 32'd0);
        send(0, sample(7, 0));
        send(1, sample(7, 1));
        send(2, sample(7, 2));
        sync = 1'b1;
        send(3, sample(7, 3));
        sync = 1'b0;
        send(4, sample(7, 4));
        send(5, sample(7, 5));
        chk("csync_v", 32'(m_valid), 32'd0);
        frame(8, 1'b1);
        wait_drain("msync");
        chk("msync_cnt2", 32'(frame_cnt), 32'd1);
        chk("msync_seq", 32'(seq_err), 32'd0);

        // Backpressure: m_ready toggles every cycle while frames stream back to back.
        fork
            begin
                for (int i = 0; i < 3 * NCH + 4; i++) begin
                    m_ready = ~m_ready;
                    tick();
                end
            end
            begin
                frame(9, 1'b1);
                frame(11, 1'b1);
                frame(12, 1'b1);
            end
        join
        m_ready = 1'b1;
        wait_drain("bp");
        chk("bp_cnt", 32'(frame_cnt), 32'd4);

        // Reset with committed data buffered.
        m_ready = 1'b0;
        do_sync();
        frame(13, 1'b0);
        frame(14, 1'b0);
        send(0, sample(5, 0));
        send(2, sample(5, 2));
        chk("prerst_v", 32'(m_valid), 32'd1);
        chk("prerst_cnt", 32'(frame_cnt), 32'd2);
        chk("prerst_seq", 32'(seq_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_v", 32'(m_valid), 32'd0);
        chk("rst2_cnt", 32'(frame_cnt), 32'd0);
        chk("rst2_seq", 32'(seq_err), 32'd0);
        chk("rst2_ovf", 32'(overflow), 32'd0);
        m_ready = 1'b1;
        repeat (3) tick();
        chk("rst2_idle_v", 32'(m_valid), 32'd0);

        // clr_err together with a new error leaves the sticky set.
        send(0, sample(6, 0));
        clr_err = 1'b1;
        send(2, sample(6, 2));
        clr_err = 1'b0;
        chk("clr_vs_set", 32'(seq_err), 32'd1);
        clear_err();
        chk("clr_alone", 32'(seq_err), 32'd0);
        repeat (3) tick();
        chk("end_v", 32'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
